// File: rtl/pc_seq_ras.sv
// Program sequencer for the stack CPU: PC stepping, conditional/relative
// branches from the data stack, CALL/RET through a small return-address
// stack, sticky error flag and a terminal halt state.
module pc_seq_ras #(
    parameter  int unsigned INST_CAP  = 20,
    parameter  int unsigned DATA_LEN  = 8,
    parameter  int unsigned RAS_DEPTH = 4,
    localparam int unsigned PC_W      = $clog2(INST_CAP) + 1,
    localparam int unsigned RL_W      = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [3:0]          op,
    input  logic                z_flag,
    input  logic                s_flag,
    input  logic [DATA_LEN-1:0] stk_data,
    output logic                stk_pop,
    output logic [PC_W-1:0]     pc,
    output logic                done,
    output logic                halted,
    output logic                err,
    output logic [RL_W-1:0]     ras_level
);

    // Index width into the RAS array and a signed-safe width for targets.
    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned TW    = ((PC_W > DATA_LEN) ? PC_W : DATA_LEN) + 2;

    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_JS   = 4'h3;
    localparam logic [3:0] OP_JNZ  = 4'h4;
    localparam logic [3:0] OP_CALL = 4'h5;
    localparam logic [3:0] OP_RET  = 4'h6;
    localparam logic [3:0] OP_BRR  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_LOAD = 3'd2,
        S_STEP = 3'd3,
        S_RETN = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                stk_pop_q, stk_pop_d;
    logic                done_q, done_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;
    logic [RL_W-1:0]     ras_level_q, ras_level_d;
    logic [PC_W-1:0]     ras_q [RAS_DEPTH];
    logic [PC_W-1:0]     ras_d [RAS_DEPTH];

    logic [PC_W-1:0]     pc_inc;
    logic [TW-1:0]       tgt;
    logic                tgt_bad;
    logic                ras_full;
    logic                ras_empty;

    // Datapath helpers: saturating increment, branch target and its legality.
    always_comb begin
        pc_inc = (pc_q < PC_W'(INST_CAP - 1)) ? pc_q + PC_W'(1) : pc_q;
        if (op_q == OP_BRR) begin
            tgt = TW'(pc_q) + TW'($signed(stk_data));
        end else begin
            tgt = TW'(stk_data);
        end
        // A negative result wraps to a huge unsigned value and fails too.
        tgt_bad   = (tgt > TW'(INST_CAP - 1));
        ras_full  = (ras_level_q == RL_W'(RAS_DEPTH));
        ras_empty = (ras_level_q == RL_W'(0));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pc_d        = pc_q;
        err_d       = err_q;
        ras_d       = ras_q;
        ras_level_d = ras_level_q;
        done_d      = 1'b0;
        stk_pop_d   = 1'b0;
        halted_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    op_d = op;
                    case (op)
                        OP_JMP, OP_CALL, OP_BRR: state_d = S_POP;
                        OP_JZ:   state_d = z_flag  ? S_POP : S_STEP;
                        OP_JS:   state_d = s_flag  ? S_POP : S_STEP;
                        OP_JNZ:  state_d = !z_flag ? S_POP : S_STEP;
                        OP_RET:  state_d = S_RETN;
                        OP_HALT: state_d = S_HALT;
                        default: state_d = S_STEP;
                    endcase
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (op_q == OP_CALL) begin
                    if (ras_full) begin
                        err_d = 1'b1;
                    end else begin
                        ras_d[IDX_W'(ras_level_q)] = pc_inc;
                        ras_level_d = ras_level_q + RL_W'(1);
                    end
                end
                if (tgt_bad) begin
                    err_d = 1'b1;
                end else begin
                    pc_d = tgt[PC_W-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_STEP: begin
                pc_d    = pc_inc;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_RETN: begin
                if (ras_empty) begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end else begin
                    pc_d        = ras_q[IDX_W'(ras_level_q - RL_W'(1))];
                    ras_level_d = ras_level_q - RL_W'(1);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stk_pop_d = (state_d == S_POP);
        halted_d  = (state_d == S_HALT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            pc_q        <= '0;
            stk_pop_q   <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            ras_level_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            stk_pop_q   <= stk_pop_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            ras_level_q <= ras_level_d;
            ras_q       <= ras_d;
        end
    end

    assign stk_pop   = stk_pop_q;
    assign pc        = pc_q;
    assign done      = done_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign ras_level = ras_level_q;

endmodule
